// File: rtl/ar_router_pkg.sv
// ----------------------------------------------------------------------------
// ar_router_pkg
// Shared definitions for the AXI4 read-address router.
//   state_e     : issue-slice state (IDLE = empty, ISSUE = holding a request)
//   *_W         : widths of the fixed-size AR sideband fields
//   clog2_min1  : index width helper that never returns zero
// ----------------------------------------------------------------------------
package ar_router_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int LOCK_W   = 2;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int QOS_W    = 4;
    localparam int REGION_W = 4;

    // A single master still needs a one-bit index field.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_qos_arbiter.sv
// ----------------------------------------------------------------------------
// rr_qos_arbiter
// Purely combinational QoS + round-robin arbiter.
//   req_i          : per-master request
//   qos_i          : per-master QoS, master i at [i*QOS_W +: QOS_W]
//   rr_ptr_i       : first master index to consider in the cyclic search
//   grant_onehot_o : one-hot grant (zero when no request)
//   grant_idx_o    : binary index of the granted master
//   any_o          : at least one master is requesting
// With QOS_EN set, only requesters holding the highest QoS are candidates;
// otherwise every requester is a candidate.
// ----------------------------------------------------------------------------
module rr_qos_arbiter
    import ar_router_pkg::*;
#(
    parameter int NM     = 2,
    parameter bit QOS_EN = 1'b1,
    parameter int IDW    = clog2_min1(NM)
) (
    input  logic [NM-1:0]       req_i,
    input  logic [NM*QOS_W-1:0] qos_i,
    input  logic [IDW-1:0]      rr_ptr_i,
    output logic [NM-1:0]       grant_onehot_o,
    output logic [IDW-1:0]      grant_idx_o,
    output logic                any_o
);

    logic [QOS_W-1:0] max_qos;
    logic [NM-1:0]    cand;

    // NOTE: every combinational output gets a default before the loops so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        max_qos = '0;
        for (int i = 0; i < NM; i++) begin
            if (req_i[i] && (qos_i[i*QOS_W +: QOS_W] > max_qos)) begin
                max_qos = qos_i[i*QOS_W +: QOS_W];
            end
        end
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < NM; i++) begin
            cand[i] = req_i[i] && (!QOS_EN || (qos_i[i*QOS_W +: QOS_W] == max_qos));
        end
    end

    // Cyclic search starting at rr_ptr_i; first candidate found wins.
    always_comb begin
        logic found;
        int   idx;
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        any_o          = |req_i;
        found          = 1'b0;
        idx            = 0;
        for (int k = 0; k < NM; k++) begin
            idx = (int'(rr_ptr_i) + k) % NM;
            if (!found && cand[idx]) begin
                found               = 1'b1;
                grant_onehot_o[idx] = 1'b1;
                grant_idx_o         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/ar_channel_router.sv
// ----------------------------------------------------------------------------
// ar_channel_router
// AXI4 AR-channel router: NM masters arbitrated (QoS then round-robin) into a
// one-entry register slice, address-decoded onto NS slave ports.
//   ACLK / ARESET        : clock, synchronous active-high reset
//   S_AXI_ar*            : per-master AR channels, master i at slice i
//   S_AXI_arready        : one-hot (or zero) accept, asserted only in IDLE
//   M_AXI_arid           : winning master index (shared by all slaves)
//   M_AXI_ar* payload    : registered payload shared by all slave ports
//   M_AXI_arvalid/ready  : per-slave handshake, arvalid one-hot
//   DECERR_valid/id/len  : one-cycle report of an accepted unmapped request
//   Busy                 : slice holds a request awaiting a slave
// ----------------------------------------------------------------------------
module ar_channel_router
    import ar_router_pkg::*;
#(
    parameter int             NM       = 2,
    parameter int             NS       = 4,
    parameter int             AW       = 32,
    parameter int             LW       = 8,
    parameter int             IDW      = clog2_min1(NM),
    parameter bit             QOS_EN   = 1'b1,
    parameter logic [NS*AW-1:0] SLV_BASE = '0,
    parameter logic [NS*AW-1:0] SLV_MASK = '0
) (
    input  logic                   ACLK,
    input  logic                   ARESET,

    input  logic [NM*AW-1:0]       S_AXI_araddr,
    input  logic [NM*LW-1:0]       S_AXI_arlen,
    input  logic [NM*SIZE_W-1:0]   S_AXI_arsize,
    input  logic [NM*BURST_W-1:0]  S_AXI_arburst,
    input  logic [NM*LOCK_W-1:0]   S_AXI_arlock,
    input  logic [NM*CACHE_W-1:0]  S_AXI_arcache,
    input  logic [NM*PROT_W-1:0]   S_AXI_arprot,
    input  logic [NM*QOS_W-1:0]    S_AXI_arqos,
    input  logic [NM*REGION_W-1:0] S_AXI_arregion,
    input  logic [NM-1:0]          S_AXI_arvalid,
    output logic [NM-1:0]          S_AXI_arready,

    output logic [IDW-1:0]         M_AXI_arid,
    output logic [AW-1:0]          M_AXI_araddr,
    output logic [LW-1:0]          M_AXI_arlen,
    output logic [SIZE_W-1:0]      M_AXI_arsize,
    output logic [BURST_W-1:0]     M_AXI_arburst,
    output logic [LOCK_W-1:0]      M_AXI_arlock,
    output logic [CACHE_W-1:0]     M_AXI_arcache,
    output logic [PROT_W-1:0]      M_AXI_arprot,
    output logic [QOS_W-1:0]       M_AXI_arqos,
    output logic [REGION_W-1:0]    M_AXI_arregion,
    output logic [NS-1:0]          M_AXI_arvalid,
    input  logic [NS-1:0]          M_AXI_arready,

    output logic                   DECERR_valid,
    output logic [IDW-1:0]         DECERR_id,
    output logic [LW-1:0]          DECERR_len,
    output logic                   Busy
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NS-1:0]       arvalid_q;
    logic [IDW-1:0]      arid_q;
    logic [AW-1:0]       addr_q;
    logic [LW-1:0]       len_q;
    logic [SIZE_W-1:0]   size_q;
    logic [BURST_W-1:0]  burst_q;
    logic [LOCK_W-1:0]   lock_q;
    logic [CACHE_W-1:0]  cache_q;
    logic [PROT_W-1:0]   prot_q;
    logic [QOS_W-1:0]    qos_q;
    logic [REGION_W-1:0] region_q;
    logic                decerr_valid_q;
    logic [IDW-1:0]      decerr_id_q;
    logic [LW-1:0]       decerr_len_q;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NM-1:0]  grant_oh;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic           grant_en;

    rr_qos_arbiter #(
        .NM     (NM),
        .QOS_EN (QOS_EN),
        .IDW    (IDW)
    ) u_arb (
        .req_i          (S_AXI_arvalid),
        .qos_i          (S_AXI_arqos),
        .rr_ptr_i       (rr_ptr_q),
        .grant_onehot_o (grant_oh),
        .grant_idx_o    (grant_idx),
        .any_o          (grant_any)
    );

    // The cycle after a DECERR acceptance is left idle so a new grant never
    // overlaps the error pulse. No handshake is offered while reset is held.
    assign grant_en      = (state_q == IDLE) && !decerr_valid_q && !ARESET && grant_any;
    assign S_AXI_arready = grant_en ? grant_oh : '0;

    assign rr_ptr_d = (grant_idx == IDW'(NM - 1)) ? '0 : grant_idx + 1'b1;

    // ------------------------------------------------------------------
    // Winner payload mux (one-hot select keeps all slices constant)
    // ------------------------------------------------------------------
    logic [AW-1:0]       sel_addr;
    logic [LW-1:0]       sel_len;
    logic [SIZE_W-1:0]   sel_size;
    logic [BURST_W-1:0]  sel_burst;
    logic [LOCK_W-1:0]   sel_lock;
    logic [CACHE_W-1:0]  sel_cache;
    logic [PROT_W-1:0]   sel_prot;
    logic [QOS_W-1:0]    sel_qos;
    logic [REGION_W-1:0] sel_region;

    always_comb begin
        sel_addr   = '0;
        sel_len    = '0;
        sel_size   = '0;
        sel_burst  = '0;
        sel_lock   = '0;
        sel_cache  = '0;
        sel_prot   = '0;
        sel_qos    = '0;
        sel_region = '0;
        for (int i = 0; i < NM; i++) begin
            if (grant_oh[i]) begin
                sel_addr   = S_AXI_araddr  [i*AW       +: AW];
                sel_len    = S_AXI_arlen   [i*LW       +: LW];
                sel_size   = S_AXI_arsize  [i*SIZE_W   +: SIZE_W];
                sel_burst  = S_AXI_arburst [i*BURST_W  +: BURST_W];
                sel_lock   = S_AXI_arlock  [i*LOCK_W   +: LOCK_W];
                sel_cache  = S_AXI_arcache [i*CACHE_W  +: CACHE_W];
                sel_prot   = S_AXI_arprot  [i*PROT_W   +: PROT_W];
                sel_qos    = S_AXI_arqos   [i*QOS_W    +: QOS_W];
                sel_region = S_AXI_arregion[i*REGION_W +: REGION_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Address decode: raw window hits, then lowest index wins on overlap
    // ------------------------------------------------------------------
    logic [NS-1:0] hit;
    logic [NS-1:0] hit_oh;

    for (genvar k = 0; k < NS; k++) begin : g_dec
        assign hit[k] = (sel_addr & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW];
    end

    always_comb begin
        logic found;
        hit_oh = '0;
        found  = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (!found && hit[k]) begin
                found     = 1'b1;
                hit_oh[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue slice FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            arvalid_q      <= '0;
            arid_q         <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            burst_q        <= '0;
            lock_q         <= '0;
            cache_q        <= '0;
            prot_q         <= '0;
            qos_q          <= '0;
            region_q       <= '0;
            decerr_valid_q <= 1'b0;
            decerr_id_q    <= '0;
            decerr_len_q   <= '0;
        end else begin
            decerr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        arid_q   <= grant_idx;
                        addr_q   <= sel_addr;
                        len_q    <= sel_len;
                        size_q   <= sel_size;
                        burst_q  <= sel_burst;
                        lock_q   <= sel_lock;
                        cache_q  <= sel_cache;
                        prot_q   <= sel_prot;
                        qos_q    <= sel_qos;
                        region_q <= sel_region;
                        rr_ptr_q <= rr_ptr_d;
                        if (|hit) begin
                            arvalid_q <= hit_oh;
                            state_q   <= ISSUE;
                        end else begin
                            decerr_valid_q <= 1'b1;
                            decerr_id_q    <= grant_idx;
                            decerr_len_q   <= sel_len;
                        end
                    end
                end
                ISSUE: begin
                    // Only the selected slave's ready matters.
                    if (|(arvalid_q & M_AXI_arready)) begin
                        arvalid_q <= '0;
                        state_q   <= IDLE;
                    end
                end
            endcase
        end
    end

    assign M_AXI_arid     = arid_q;
    assign M_AXI_araddr   = addr_q;
    assign M_AXI_arlen    = len_q;
    assign M_AXI_arsize   = size_q;
    assign M_AXI_arburst  = burst_q;
    assign M_AXI_arlock   = lock_q;
    assign M_AXI_arcache  = cache_q;
    assign M_AXI_arprot   = prot_q;
    assign M_AXI_arqos    = qos_q;
    assign M_AXI_arregion = region_q;
    assign M_AXI_arvalid  = arvalid_q;
    assign DECERR_valid   = decerr_valid_q;
    assign DECERR_id      = decerr_id_q;
    assign DECERR_len     = decerr_len_q;
    assign Busy           = (state_q == ISSUE);

endmodule

// File: tb/tb_ar_channel_router.sv
// ----------------------------------------------------------------------------
// tb_ar_channel_router
// Self-checking bench for ar_channel_router with NM = 4, NS = 4.
// Windows: slave0 0x4xxxxxxx, slave1 0x1xxxxxxx, slave2 0x4..0x7xxxxxxx
// (overlaps slave0), slave3 0x2xxxxxxx; everything else is unmapped.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_ar_channel_router;

    localparam int NM  = 4;
    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int IDW = 2;

    localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h4000_0000, 32'h1000_0000, 32'h4000_0000};
    localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hC000_0000, 32'hF000_0000, 32'hF000_0000};

    logic              ACLK;
    logic              ARESET;
    logic [NM*AW-1:0]  s_araddr;
    logic [NM*LW-1:0]  s_arlen;
    logic [NM*3-1:0]   s_arsize;
    logic [NM*2-1:0]   s_arburst;
    logic [NM*2-1:0]   s_arlock;
    logic [NM*4-1:0]   s_arcache;
    logic [NM*3-1:0]   s_arprot;
    logic [NM*4-1:0]   s_arqos;
    logic [NM*4-1:0]   s_arregion;
    logic [NM-1:0]     s_arvalid;
    logic [NM-1:0]     s_arready;
    logic [IDW-1:0]    m_arid;
    logic [AW-1:0]     m_araddr;
    logic [LW-1:0]     m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic [1:0]        m_arlock;
    logic [3:0]        m_arcache;
    logic [2:0]        m_arprot;
    logic [3:0]        m_arqos;
    logic [3:0]        m_arregion;
    logic [NS-1:0]     m_arvalid;
    logic [NS-1:0]     m_arready;
    logic              dec_valid;
    logic [IDW-1:0]    dec_id;
    logic [LW-1:0]     dec_len;
    logic              busy;

    ar_channel_router #(
        .NM(NM), .NS(NS), .AW(AW), .LW(LW), .IDW(IDW), .QOS_EN(1'b1),
        .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_araddr(s_araddr), .S_AXI_arlen(s_arlen), .S_AXI_arsize(s_arsize),
        .S_AXI_arburst(s_arburst), .S_AXI_arlock(s_arlock), .S_AXI_arcache(s_arcache),
        .S_AXI_arprot(s_arprot), .S_AXI_arqos(s_arqos), .S_AXI_arregion(s_arregion),
        .S_AXI_arvalid(s_arvalid), .S_AXI_arready(s_arready),
        .M_AXI_arid(m_arid), .M_AXI_araddr(m_araddr), .M_AXI_arlen(m_arlen),
        .M_AXI_arsize(m_arsize), .M_AXI_arburst(m_arburst), .M_AXI_arlock(m_arlock),
        .M_AXI_arcache(m_arcache), .M_AXI_arprot(m_arprot), .M_AXI_arqos(m_arqos),
        .M_AXI_arregion(m_arregion), .M_AXI_arvalid(m_arvalid), .M_AXI_arready(m_arready),
        .DECERR_valid(dec_valid), .DECERR_id(dec_id), .DECERR_len(dec_len),
        .Busy(busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        s_arvalid = '0;
    endtask

    // Sideband fields are derived from the request so pass-through is checkable.
    task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l, input logic [3:0] q);
        s_araddr  [i*AW +: AW] = a;
        s_arlen   [i*LW +: LW] = l;
        s_arsize  [i*3  +: 3]  = l[2:0];
        s_arburst [i*2  +: 2]  = 2'b01;
        s_arlock  [i*2  +: 2]  = 2'(i);
        s_arcache [i*4  +: 4]  = ~q;
        s_arprot  [i*3  +: 3]  = 3'(i);
        s_arqos   [i*4  +: 4]  = q;
        s_arregion[i*4  +: 4]  = q;
        s_arvalid[i]           = 1'b1;
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model state (random phase)
    // ------------------------------------------------------------------
    logic [31:0] win_base [NS] = '{32'h4000_0000, 32'h1000_0000, 32'h4000_0000, 32'h2000_0000};
    logic [31:0] win_mask [NS] = '{32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'hF000_0000};
    logic [3:0]  tops     [7]  = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h7, 4'hF};

    bit          pend  [NM];
    logic [31:0] p_addr[NM];
    logic [7:0]  p_len [NM];
    logic [3:0]  p_qos [NM];
    int          ptr;

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < NS; k++) begin
            if ((a & win_mask[k]) == win_base[k]) return k;
        end
        return -1;
    endfunction

    function automatic int pick_winner();
        int maxq = -1;
        for (int i = 0; i < NM; i++) begin
            if (pend[i] && int'(p_qos[i]) > maxq) maxq = int'(p_qos[i]);
        end
        for (int k = 0; k < NM; k++) begin
            int idx = (ptr + k) % NM;
            if (pend[idx] && int'(p_qos[idx]) == maxq) return idx;
        end
        return -1;
    endfunction

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  qos;
        int          slv;   // -1 = unmapped
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{1, 32'h1000_0040, 8'd3,   4'd0, 1};
        vecs[1] = '{0, 32'hF000_0000, 8'd7,   4'd1, -1};
        vecs[2] = '{2, 32'h4000_1000, 8'd1,   4'd2, 0};
        vecs[3] = '{3, 32'h5000_0010, 8'hFF,  4'd3, 2};
        vecs[4] = '{0, 32'h2ABC_0000, 8'h10,  4'd4, 3};
        vecs[5] = '{3, 32'h0000_0000, 8'd2,   4'd5, -1};
        vecs[6] = '{1, 32'hFFFF_FFFC, 8'h80,  4'd6, -1};
        vecs[7] = '{2, 32'h7FFF_FFFF, 8'd0,   4'd7, 2};

        ARESET    = 1'b1;
        s_araddr  = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arlock = '0;
        s_arcache = '0; s_arprot = '0; s_arqos = '0; s_arregion = '0; s_arvalid = '0;
        m_arready = '0;

        // ---------------- reset state ----------------
        @(negedge ACLK);
        set_req(0, 32'h1000_0000, 8'd1, 4'd0);
        #1 check("rst_arready_held", 64'(s_arready), 64'h0);
        do_reset();
        clear_reqs();
        #1;
        check("rst_arvalid", 64'(m_arvalid), 64'h0);
        check("rst_busy",    64'(busy),      64'h0);
        check("rst_decerr",  64'(dec_valid), 64'h0);
        check("rst_payload", {m_arid, m_araddr, m_arlen, m_arqos}, 64'h0);
        check("rst_decfld",  64'({dec_id, dec_len}), 64'h0);

        // ---------------- table-driven single transactions ----------------
        for (int t = 0; t < 8; t++) begin
            @(negedge ACLK);
            clear_reqs();
            m_arready = '0;
            set_req(vecs[t].m, vecs[t].addr, vecs[t].len, vecs[t].qos);
            #1 check($sformatf("tbl%0d_arready", t), 64'(s_arready), 64'(1) << vecs[t].m);
            @(negedge ACLK);
            clear_reqs();
            #1;
            if (vecs[t].slv < 0) begin
                check($sformatf("tbl%0d_decerr", t),  64'(dec_valid), 64'h1);
                check($sformatf("tbl%0d_dec_id", t),  64'(dec_id),    64'(vecs[t].m));
                check($sformatf("tbl%0d_dec_len", t), 64'(dec_len),   64'(vecs[t].len));
                check($sformatf("tbl%0d_novalid", t), 64'(m_arvalid), 64'h0);
                check($sformatf("tbl%0d_nobusy", t),  64'(busy),      64'h0);
            end else begin
                check($sformatf("tbl%0d_arvalid", t), 64'(m_arvalid), 64'(1) << vecs[t].slv);
                check($sformatf("tbl%0d_arid", t),    64'(m_arid),    64'(vecs[t].m));
                check($sformatf("tbl%0d_araddr", t),  64'(m_araddr),  64'(vecs[t].addr));
                check($sformatf("tbl%0d_arlen", t),   64'(m_arlen),   64'(vecs[t].len));
                check($sformatf("tbl%0d_side", t),
                      64'({m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arregion, m_arqos}),
                      64'({vecs[t].len[2:0], 2'b01, 2'(vecs[t].m), ~vecs[t].qos, 3'(vecs[t].m),
                           vecs[t].qos, vecs[t].qos}));
                check($sformatf("tbl%0d_busy", t),    64'(busy),      64'h1);
                check($sformatf("tbl%0d_nodec", t),   64'(dec_valid), 64'h0);
            end
            m_arready = '1;
            @(negedge ACLK);
            #1;
            check($sformatf("tbl%0d_done_valid", t), 64'(m_arvalid), 64'h0);
            check($sformatf("tbl%0d_done_dec", t),   64'(dec_valid), 64'h0);
            check($sformatf("tbl%0d_done_busy", t),  64'(busy),      64'h0);
        end

        // ---------------- single request, slave stalls ----------------
        @(negedge ACLK);
        m_arready = '0;
        set_req(1, 32'h1000_0040, 8'd3, 4'd0);
        #1 check("single_arready", 64'(s_arready), 64'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            clear_reqs();
            m_arready = 4'b1101;  // other slaves ready: must be ignored
            #1;
            check($sformatf("single_hold%0d_valid", c), 64'(m_arvalid), 64'h2);
            check($sformatf("single_hold%0d_id", c),    64'(m_arid),    64'h1);
            check($sformatf("single_hold%0d_len", c),   64'(m_arlen),   64'h3);
            check($sformatf("single_hold%0d_rdy", c),   64'(s_arready), 64'h0);
        end
        m_arready = 4'b0010;
        @(negedge ACLK);
        m_arready = '0;
        #1 check("single_cleared", 64'(m_arvalid), 64'h0);

        // ---------------- QoS priority ----------------
        @(negedge ACLK);
        set_req(0, 32'h1000_0000, 8'd1, 4'd2);
        set_req(1, 32'h2000_0000, 8'd2, 4'd9);
        #1 check("qos_first", 64'(s_arready), 64'h2);
        @(negedge ACLK);
        s_arvalid[1] = 1'b0;
        m_arready = '1;
        #1;
        check("qos_first_slave", 64'(m_arvalid), 64'h8);
        check("qos_first_id",    64'(m_arid),    64'h1);
        check("qos_gap",         64'(s_arready), 64'h0);
        @(negedge ACLK);
        #1 check("qos_second", 64'(s_arready), 64'h1);
        @(negedge ACLK);
        clear_reqs();
        #1;
        check("qos_second_slave", 64'(m_arvalid), 64'h2);
        check("qos_second_id",    64'(m_arid),    64'h0);
        @(negedge ACLK);

        // ---------------- round-robin fairness ----------------
        do_reset();
        m_arready = '1;
        for (int i = 0; i < NM; i++) set_req(i, 32'h1000_0000 + 32'(i), 8'(i), 4'd5);
        for (int g = 0; g < 5; g++) begin
            #1 check($sformatf("rr%0d_grant", g), 64'(s_arready), 64'(1) << (g % NM));
            @(negedge ACLK);
            #1;
            check($sformatf("rr%0d_gap", g), 64'(s_arready), 64'h0);
            check($sformatf("rr%0d_id", g),  64'(m_arid),    64'(g % NM));
            @(negedge ACLK);
        end
        clear_reqs();
        @(negedge ACLK);

        // ---------------- reset mid-ISSUE ----------------
        do_reset();
        m_arready = '0;
        set_req(0, 32'h1000_0000, 8'd4, 4'd0);
        #1 check("rmid_grant", 64'(s_arready), 64'h1);
        @(negedge ACLK);
        clear_reqs();
        #1 check("rmid_busy", 64'(busy), 64'h1);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check("rmid_valid", 64'(m_arvalid), 64'h0);
        check("rmid_idle",  64'(busy),      64'h0);
        for (int i = 0; i < NM; i++) set_req(i, 32'h1000_0000, 8'd0, 4'd1);
        #1 check("rmid_ptr0", 64'(s_arready), 64'h1);
        @(negedge ACLK);
        clear_reqs();
        m_arready = '1;
        @(negedge ACLK);

        // ---------------- randomized vs reference model ----------------
        do_reset();
        begin
            bit          m_busy = 0;
            int          m_slv  = 0;
            logic [1:0]  m_id   = '0;
            logic [31:0] m_addr = '0;
            logic [7:0]  m_len  = '0;
            bit          m_dec  = 0;
            logic [1:0]  m_did  = '0;
            logic [7:0]  m_dlen = '0;
            ptr = 0;
            for (int i = 0; i < NM; i++) pend[i] = 0;
            for (int cyc = 0; cyc < 400; cyc++) begin
                int w;
                bit new_dec;
                for (int i = 0; i < NM; i++) begin
                    if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                        pend[i]   = 1;
                        p_addr[i] = {tops[$urandom_range(0, 6)], 28'($urandom)};
                        p_len[i]  = 8'($urandom);
                        p_qos[i]  = 4'($urandom_range(0, 3));
                    end
                end
                clear_reqs();
                for (int i = 0; i < NM; i++) if (pend[i]) set_req(i, p_addr[i], p_len[i], p_qos[i]);
                m_arready = 4'($urandom);
                #1;
                w = (!m_busy && !m_dec) ? pick_winner() : -1;
                check("rnd_arready", 64'(s_arready), (w >= 0) ? (64'(1) << w) : 64'h0);
                check("rnd_arvalid", 64'(m_arvalid), m_busy ? (64'(1) << m_slv) : 64'h0);
                check("rnd_busy",    64'(busy),      64'(m_busy));
                check("rnd_decerr",  64'(dec_valid), 64'(m_dec));
                if (m_busy) check("rnd_payload", {m_arid, m_araddr, m_arlen}, {m_id, m_addr, m_len});
                if (m_dec)  check("rnd_decfld",  64'({dec_id, dec_len}), 64'({m_did, m_dlen}));
                new_dec = 0;
                if (m_busy) begin
                    if (m_arready[m_slv]) m_busy = 0;
                end else if (w >= 0) begin
                    int s;
                    pend[w] = 0;
                    ptr     = (w + 1) % NM;
                    s       = decode(p_addr[w]);
                    if (s >= 0) begin
                        m_busy = 1;
                        m_slv  = s;
                        m_id   = 2'(w);
                        m_addr = p_addr[w];
                        m_len  = p_len[w];
                    end else begin
                        new_dec = 1;
                        m_did   = 2'(w);
                        m_dlen  = p_len[w];
                    end
                end
                m_dec = new_dec;
                @(negedge ACLK);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
